// File: rtl/mem_request_scheduler.sv
// -----------------------------------------------------------------------------
// mem_request_scheduler
//
// Puts three requesters (page-table walker, data memory, instruction fetch)
// onto a single memory port, one access at a time.
//
// Requester handshake: a requester raises *_request with its fields valid and
// holds them until its *_done pulses for one cycle. Fields are captured when
// the request is granted, so they may change after the grant. A request
// dropped after the grant still completes and still gets its done pulse.
// Memory handshake: mem_enable stays high with constant mem_* fields until
// the cycle in which mem_valid is sampled high. mem_valid is ignored while
// mem_enable is low.
//
// Ports:
//   clk, reset                 clock (rising edge), sync active-high reset
//   ptw_request/addr/done      PTW read port (highest priority)
//   fetch_request/addr/done    instruction read port
//   dmem_request/cmd/addr/
//   dmem_write_data/mask/done  data read/write port
//   read_data                  registered read data, valid while a *_done is high
//   busy                       high whenever the scheduler is not idle
//   timeout_error              sticky memory-timeout flag, cleared only by reset
//   mem_enable/cmd/addr/
//   mem_write_data/mask        memory request, driven only during an access
//   mem_read_data, mem_valid   memory response
// -----------------------------------------------------------------------------
`ifndef MEM_CMD_READ
`define MEM_CMD_READ 1'b0
`endif
`ifndef MEM_CMD_WRITE
`define MEM_CMD_WRITE 1'b1
`endif

module mem_request_scheduler #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ptw_request,
  input  logic [31:0] ptw_addr,
  output logic        ptw_done,
  input  logic        fetch_request,
  input  logic [31:0] fetch_addr,
  output logic        fetch_done,
  input  logic        dmem_request,
  input  logic        dmem_cmd,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_write_data,
  input  logic [3:0]  dmem_write_mask,
  output logic        dmem_done,
  output logic [31:0] read_data,
  output logic        busy,
  output logic        timeout_error,
  output logic        mem_enable,
  output logic        mem_cmd,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic [3:0]  mem_write_mask,
  input  logic [31:0] mem_read_data,
  input  logic        mem_valid
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_PTW, OWN_FETCH, OWN_DMEM} owner_t;

  // Round-robin preference between fetch and dmem only; PTW bypasses it.
  localparam logic PREF_FETCH = 1'b0;
  localparam logic PREF_DMEM  = 1'b1;

  // Last ACCESS cycle index before the access is declared timed out.
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  logic              rr_pref_q, rr_pref_d;
  logic              cmd_q, cmd_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        mask_q, mask_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [31:0]       read_data_q, read_data_d;
  logic              timeout_q, timeout_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_NONE;
      rr_pref_q   <= PREF_FETCH;
      cmd_q       <= `MEM_CMD_READ;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      mask_q      <= 4'h0;
      wait_cnt_q  <= '0;
      read_data_q <= 32'h0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_pref_q   <= rr_pref_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mask_q      <= mask_d;
      wait_cnt_q  <= wait_cnt_d;
      read_data_q <= read_data_d;
      timeout_q   <= timeout_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_pref_d   = rr_pref_q;
    cmd_d       = cmd_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    mask_d      = mask_q;
    wait_cnt_d  = wait_cnt_q;
    read_data_d = read_data_q;
    timeout_d   = timeout_q;

    case (state_q)
      S_IDLE: begin
        wait_cnt_d = '0;
        if (ptw_request) begin
          state_d = S_ACCESS;
          owner_d = OWN_PTW;
          cmd_d   = `MEM_CMD_READ;
          addr_d  = ptw_addr;
          wdata_d = 32'h0;
          mask_d  = 4'hF;
        end else if (fetch_request && (!dmem_request || rr_pref_q == PREF_FETCH)) begin
          state_d   = S_ACCESS;
          owner_d   = OWN_FETCH;
          rr_pref_d = PREF_DMEM;
          cmd_d     = `MEM_CMD_READ;
          addr_d    = fetch_addr;
          wdata_d   = 32'h0;
          mask_d    = 4'hF;
        end else if (dmem_request) begin
          state_d   = S_ACCESS;
          owner_d   = OWN_DMEM;
          rr_pref_d = PREF_FETCH;
          cmd_d     = dmem_cmd;
          addr_d    = dmem_addr;
          wdata_d   = dmem_write_data;
          mask_d    = dmem_write_mask;
        end
      end
      S_ACCESS: begin
        // A response in the last allowed cycle beats the timeout.
        if (mem_valid) begin
          state_d = S_DONE;
          if (cmd_q == `MEM_CMD_READ) read_data_d = mem_read_data;
        end else if (wait_cnt_q == TIMEOUT_LAST) begin
          state_d     = S_DONE;
          timeout_d   = 1'b1;
          read_data_d = 32'h0;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        wait_cnt_d = '0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Everything below is decoded from registers only.
  assign mem_enable     = (state_q == S_ACCESS);
  assign mem_cmd        = mem_enable ? cmd_q   : 1'b0;
  assign mem_addr       = mem_enable ? addr_q  : 32'h0;
  assign mem_write_data = mem_enable ? wdata_q : 32'h0;
  assign mem_write_mask = mem_enable ? mask_q  : 4'h0;

  assign ptw_done       = (state_q == S_DONE) && (owner_q == OWN_PTW);
  assign fetch_done     = (state_q == S_DONE) && (owner_q == OWN_FETCH);
  assign dmem_done      = (state_q == S_DONE) && (owner_q == OWN_DMEM);

  assign busy           = (state_q != S_IDLE);
  assign read_data      = read_data_q;
  assign timeout_error  = timeout_q;

endmodule

// File: tb/tb_mem_request_scheduler.sv
module tb_mem_request_scheduler;

  localparam logic CMD_RD = 1'b0;
  localparam logic CMD_WR = 1'b1;
  localparam logic [2:0] ID_PTW = 3'b100, ID_FETCH = 3'b010, ID_DMEM = 3'b001;
  localparam int TO_CYC = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        ptw_request, fetch_request, dmem_request;
  logic [31:0] ptw_addr, fetch_addr, dmem_addr, dmem_write_data;
  logic        dmem_cmd;
  logic [3:0]  dmem_write_mask;
  logic        ptw_done, fetch_done, dmem_done;
  logic [31:0] read_data;
  logic        busy, timeout_error;
  logic        mem_enable, mem_cmd;
  logic [31:0] mem_addr, mem_write_data, mem_read_data;
  logic [3:0]  mem_write_mask;
  logic        mem_valid;

  int checks = 0;
  int failures = 0;

  // Reference state: round-robin preference (0 = fetch, 1 = dmem) and the
  // value read_data should hold after the last completed access.
  logic        model_pref;
  logic [31:0] model_rd;

  mem_request_scheduler #(.TIMEOUT_CYCLES(TO_CYC), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .ptw_request(ptw_request), .ptw_addr(ptw_addr), .ptw_done(ptw_done),
    .fetch_request(fetch_request), .fetch_addr(fetch_addr), .fetch_done(fetch_done),
    .dmem_request(dmem_request), .dmem_cmd(dmem_cmd), .dmem_addr(dmem_addr),
    .dmem_write_data(dmem_write_data), .dmem_write_mask(dmem_write_mask),
    .dmem_done(dmem_done), .read_data(read_data), .busy(busy),
    .timeout_error(timeout_error), .mem_enable(mem_enable), .mem_cmd(mem_cmd),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_write_mask(mem_write_mask), .mem_read_data(mem_read_data),
    .mem_valid(mem_valid)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    ptw_request = 0; fetch_request = 0; dmem_request = 0; mem_valid = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_pref = 1'b0;
    model_rd   = 32'h0;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [2:0] pick(input logic p, input logic f, input logic d,
                                      input logic pref);
    if (p) return ID_PTW;
    if (f && d) return pref ? ID_DMEM : ID_FETCH;
    if (f) return ID_FETCH;
    if (d) return ID_DMEM;
    return 3'b000;
  endfunction

  // ---------------- driver: memory device for one access ----------------
  // Waits for mem_enable, answers in ACCESS cycle `delay` (0 = never), then
  // samples the DONE cycle and the cycle after it. Returns observations only.
  task automatic serve_one(input int delay, input logic [31:0] rdata, input bit drop,
                           output logic [31:0] o_addr, output logic o_cmd,
                           output logic [31:0] o_wdata, output logic [3:0] o_mask,
                           output bit o_stable, output int o_acc,
                           output logic [2:0] o_done, output logic [31:0] o_rd,
                           output logic o_to, output logic [2:0] o_done2,
                           output logic o_busy2, output bit o_ok);
    o_ok = 0; o_stable = 1; o_acc = 0; o_done = 0; o_done2 = 0; o_rd = 0;
    o_to = 0; o_busy2 = 0; o_addr = 0; o_cmd = 0; o_wdata = 0; o_mask = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (mem_enable) break;
    end
    if (!mem_enable) return;
    o_addr = mem_addr; o_cmd = mem_cmd; o_wdata = mem_write_data; o_mask = mem_write_mask;
    while (mem_enable && o_acc < 40) begin
      o_acc++;
      if (mem_addr !== o_addr || mem_cmd !== o_cmd || mem_write_data !== o_wdata ||
          mem_write_mask !== o_mask) o_stable = 0;
      mem_valid     = (o_acc == delay);
      mem_read_data = (o_acc == delay) ? rdata : $urandom();
      @(negedge clk);
      mem_valid = 1'b0;
    end
    if (mem_enable) return;
    o_done = {ptw_done, fetch_done, dmem_done};
    o_rd   = read_data;
    o_to   = timeout_error;
    if (drop) begin
      if (ptw_done) ptw_request = 0;
      if (fetch_done) fetch_request = 0;
      if (dmem_done) dmem_request = 0;
    end
    @(negedge clk);
    o_done2 = {ptw_done, fetch_done, dmem_done};
    o_busy2 = busy;
    o_ok = 1;
  endtask

  // shared observation variables
  logic [31:0] g_addr, g_wdata, g_rd;
  logic        g_cmd, g_to, g_busy2;
  logic [3:0]  g_mask;
  logic [2:0]  g_done, g_done2;
  bit          g_stable, g_ok;
  int          g_acc;

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    checks++; if ({busy, mem_enable, ptw_done, fetch_done, dmem_done} !== 5'b0) begin
      failures++; $display("FAIL reset_ctrl: got %b expected 00000",
                           {busy, mem_enable, ptw_done, fetch_done, dmem_done}); end
    checks++; if (read_data !== 32'h0 || timeout_error !== 1'b0) begin
      failures++; $display("FAIL reset_data: read_data=%h to=%b expected 0/0",
                           read_data, timeout_error); end
    checks++; if ({mem_cmd, mem_addr, mem_write_data, mem_write_mask} !== 69'h0) begin
      failures++; $display("FAIL reset_mem: addr=%h wdata=%h mask=%h expected 0",
                           mem_addr, mem_write_data, mem_write_mask); end
  endtask

  task automatic test_single_fetch();
    fetch_addr = 32'h100; fetch_request = 1;
    serve_one(3, 32'hCAFEF00D, 1, g_addr, g_cmd, g_wdata, g_mask, g_stable, g_acc,
              g_done, g_rd, g_to, g_done2, g_busy2, g_ok);
    model_pref = 1'b1; model_rd = 32'hCAFEF00D;
    checks++; if (!g_ok) begin failures++; $display("FAIL single_ok: no completion"); end
    checks++; if (g_addr !== 32'h100 || g_cmd !== CMD_RD || g_mask !== 4'hF || g_wdata !== 0) begin
      failures++; $display("FAIL single_fields: addr=%h cmd=%b mask=%h wdata=%h expected 100/0/f/0",
                           g_addr, g_cmd, g_mask, g_wdata); end
    checks++; if (g_acc !== 3 || !g_stable) begin
      failures++; $display("FAIL single_access: cycles=%0d stable=%0d expected 3/1", g_acc, g_stable); end
    checks++; if (g_done !== ID_FETCH || g_rd !== 32'hCAFEF00D) begin
      failures++; $display("FAIL single_done: done=%b rd=%h expected 010/cafef00d", g_done, g_rd); end
    checks++; if (g_done2 !== 3'b0 || g_busy2 !== 1'b0) begin
      failures++; $display("FAIL single_after: done=%b busy=%b expected 000/0", g_done2, g_busy2); end
  endtask

  // Fetch and dmem held continuously; several consecutive grants.
  task automatic test_alternate();
    logic [2:0] exp_id;
    logic [31:0] exp_addr, exp_wdata, rdata;
    logic [3:0] exp_mask;
    logic exp_cmd;
    int dly;
    do_reset();
    fetch_request = 1; dmem_request = 1;
    for (int i = 0; i < 8; i++) begin
      fetch_addr      = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      dmem_addr       = $urandom();
      dmem_cmd        = $urandom_range(0, 1);
      dmem_write_data = $urandom();
      dmem_write_mask = $urandom_range(0, 15);
      rdata = $urandom(); dly = $urandom_range(1, 4);
      exp_id = pick(1'b0, 1'b1, 1'b1, model_pref);
      if (exp_id == ID_FETCH) begin
        exp_addr = fetch_addr; exp_cmd = CMD_RD; exp_wdata = 0; exp_mask = 4'hF;
        model_pref = 1'b1;
      end else begin
        exp_addr = dmem_addr; exp_cmd = dmem_cmd; exp_wdata = dmem_write_data;
        exp_mask = dmem_write_mask; model_pref = 1'b0;
      end
      if (exp_cmd == CMD_RD) model_rd = rdata;
      serve_one(dly, rdata, 0, g_addr, g_cmd, g_wdata, g_mask, g_stable, g_acc,
                g_done, g_rd, g_to, g_done2, g_busy2, g_ok);
      checks++; if (!g_ok || g_done !== exp_id) begin
        failures++; $display("FAIL alt_grant[%0d]: done=%b ok=%0d expected %b", i, g_done, g_ok, exp_id); end
      checks++; if (g_addr !== exp_addr || g_cmd !== exp_cmd || g_wdata !== exp_wdata ||
                    g_mask !== exp_mask || !g_stable) begin
        failures++; $display("FAIL alt_fields[%0d]: addr=%h cmd=%b wdata=%h mask=%h expected %h/%b/%h/%h",
                             i, g_addr, g_cmd, g_wdata, g_mask, exp_addr, exp_cmd, exp_wdata, exp_mask); end
      checks++; if (g_rd !== model_rd || g_acc !== dly) begin
        failures++; $display("FAIL alt_data[%0d]: rd=%h cycles=%0d expected %h/%0d",
                             i, g_rd, g_acc, model_rd, dly); end
    end
    fetch_request = 0; dmem_request = 0;
  endtask

  task automatic test_priority();
    logic [2:0] exp_id;
    logic [31:0] exp_addr, rdata;
    do_reset();
    ptw_addr = $urandom(); fetch_addr = $urandom(); dmem_addr = $urandom();
    dmem_cmd = CMD_RD;
    ptw_request = 1; fetch_request = 1; dmem_request = 1;
    for (int i = 0; i < 3; i++) begin
      exp_id = pick(ptw_request, fetch_request, dmem_request, model_pref);
      if (exp_id == ID_FETCH) model_pref = 1'b1;
      if (exp_id == ID_DMEM) model_pref = 1'b0;
      exp_addr = (exp_id == ID_PTW) ? ptw_addr : (exp_id == ID_FETCH) ? fetch_addr : dmem_addr;
      rdata = $urandom(); model_rd = rdata;
      serve_one($urandom_range(1, 3), rdata, 1, g_addr, g_cmd, g_wdata, g_mask, g_stable,
                g_acc, g_done, g_rd, g_to, g_done2, g_busy2, g_ok);
      checks++; if (!g_ok || g_done !== exp_id || g_addr !== exp_addr || g_rd !== model_rd) begin
        failures++; $display("FAIL prio[%0d]: done=%b addr=%h rd=%h expected %b/%h/%h",
                             i, g_done, g_addr, g_rd, exp_id, exp_addr, model_rd); end
      checks++; if (g_done2 !== 3'b0) begin
        failures++; $display("FAIL prio_pulse[%0d]: done=%b expected 000", i, g_done2); end
    end
  endtask

  task automatic test_dmem_write();
    dmem_addr = 32'h2000; dmem_write_data = 32'h11223344; dmem_write_mask = 4'b0011;
    dmem_cmd = CMD_WR; dmem_request = 1;
    serve_one($urandom_range(1, 4), $urandom(), 1, g_addr, g_cmd, g_wdata, g_mask,
              g_stable, g_acc, g_done, g_rd, g_to, g_done2, g_busy2, g_ok);
    model_pref = 1'b0;
    checks++; if (!g_ok || g_addr !== 32'h2000 || g_cmd !== CMD_WR || g_wdata !== 32'h11223344 ||
                  g_mask !== 4'b0011 || !g_stable) begin
      failures++; $display("FAIL wr_fields: addr=%h cmd=%b wdata=%h mask=%h stable=%0d expected 2000/1/11223344/3/1",
                           g_addr, g_cmd, g_wdata, g_mask, g_stable); end
    checks++; if (g_done !== ID_DMEM || g_done2 !== 3'b0) begin
      failures++; $display("FAIL wr_done: done=%b next=%b expected 001/000", g_done, g_done2); end
    checks++; if (g_rd !== model_rd) begin
      failures++; $display("FAIL wr_rdata: rd=%h expected %h", g_rd, model_rd); end
    dmem_cmd = CMD_RD;
  endtask

  task automatic test_mem_valid_idle();
    for (int i = 0; i < 4; i++) begin
      mem_valid = 1'b1; mem_read_data = $urandom();
      @(negedge clk);
      mem_valid = 1'b0;
      checks++; if (busy !== 1'b0 || read_data !== model_rd || mem_enable !== 1'b0) begin
        failures++; $display("FAIL idle_valid[%0d]: busy=%b rd=%h en=%b expected 0/%h/0",
                             i, busy, read_data, mem_enable, model_rd); end
    end
  endtask

  task automatic test_timeout();
    logic [31:0] rdata;
    // Response in the last allowed cycle: no error.
    rdata = $urandom();
    fetch_addr = $urandom(); fetch_request = 1;
    serve_one(TO_CYC, rdata, 1, g_addr, g_cmd, g_wdata, g_mask, g_stable, g_acc,
              g_done, g_rd, g_to, g_done2, g_busy2, g_ok);
    model_rd = rdata;
    checks++; if (!g_ok || g_acc !== TO_CYC || g_to !== 1'b0 || g_rd !== rdata || g_done !== ID_FETCH) begin
      failures++; $display("FAIL to_edge: cycles=%0d to=%b rd=%h done=%b expected %0d/0/%h/010",
                           g_acc, g_to, g_rd, g_done, TO_CYC, rdata); end
    // No response at all.
    fetch_request = 1;
    serve_one(0, 32'h0, 1, g_addr, g_cmd, g_wdata, g_mask, g_stable, g_acc,
              g_done, g_rd, g_to, g_done2, g_busy2, g_ok);
    model_rd = 32'h0;
    checks++; if (!g_ok || g_acc !== TO_CYC || g_to !== 1'b1 || g_rd !== 32'h0 || g_done !== ID_FETCH) begin
      failures++; $display("FAIL to_fire: cycles=%0d to=%b rd=%h done=%b expected %0d/1/0/010",
                           g_acc, g_to, g_rd, g_done, TO_CYC); end
    // Later access still completes; flag stays set.
    rdata = $urandom(); dmem_addr = $urandom(); dmem_cmd = CMD_RD; dmem_request = 1;
    serve_one(2, rdata, 1, g_addr, g_cmd, g_wdata, g_mask, g_stable, g_acc,
              g_done, g_rd, g_to, g_done2, g_busy2, g_ok);
    model_rd = rdata;
    checks++; if (!g_ok || g_done !== ID_DMEM || g_rd !== rdata || g_to !== 1'b1) begin
      failures++; $display("FAIL to_sticky: done=%b rd=%h to=%b expected 001/%h/1", g_done, g_rd, g_to, rdata); end
  endtask

  task automatic test_reset_mid_access();
    int n;
    fetch_addr = $urandom(); fetch_request = 1;
    n = 0;
    while (!mem_enable && n < 20) begin @(negedge clk); n++; end
    checks++; if (mem_enable !== 1'b1) begin
      failures++; $display("FAIL rst_mid_grant: mem_enable=%b expected 1", mem_enable); end
    @(negedge clk);                 // second ACCESS cycle
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_pref = 1'b0; model_rd = 32'h0;
    checks++; if (mem_enable !== 1'b0 || {ptw_done, fetch_done, dmem_done} !== 3'b0 ||
                  timeout_error !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL rst_mid: en=%b done=%b to=%b busy=%b expected 0/000/0/0", mem_enable,
                           {ptw_done, fetch_done, dmem_done}, timeout_error, busy); end
    dmem_addr = $urandom(); dmem_request = 1;
    serve_one(1, 32'h5A5A1234, 1, g_addr, g_cmd, g_wdata, g_mask, g_stable, g_acc,
              g_done, g_rd, g_to, g_done2, g_busy2, g_ok);
    checks++; if (!g_ok || g_done !== ID_FETCH || g_addr !== fetch_addr) begin
      failures++; $display("FAIL rst_mid_next: done=%b addr=%h expected 010/%h", g_done, g_addr, fetch_addr); end
    serve_one(1, 32'h0BADBEEF, 1, g_addr, g_cmd, g_wdata, g_mask, g_stable, g_acc,
              g_done, g_rd, g_to, g_done2, g_busy2, g_ok);
    checks++; if (!g_ok || g_done !== ID_DMEM || g_rd !== 32'h0BADBEEF) begin
      failures++; $display("FAIL rst_mid_dmem: done=%b rd=%h expected 001/0badbeef", g_done, g_rd); end
  endtask

  initial begin
    reset = 1'b1;
    ptw_request = 0; fetch_request = 0; dmem_request = 0;
    ptw_addr = 0; fetch_addr = 0; dmem_addr = 0; dmem_cmd = CMD_RD;
    dmem_write_data = 0; dmem_write_mask = 0; mem_read_data = 0; mem_valid = 0;
    model_pref = 1'b0; model_rd = 32'h0;
    repeat (2) @(posedge clk);
    test_reset();
    test_single_fetch();
    test_alternate();
    test_priority();
    test_dmem_write();
    test_mem_valid_idle();
    test_timeout();
    test_reset_mid_access();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
